// File: rtl/ecap5_dproc_pkg.sv
// Shared ECAP5-DPROC core constants and register-address type.
package ecap5_dproc_pkg;
  localparam int NB_REGS        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int XLEN           = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, flags looked up
// for both read ports against the next-state vector.
module reg_scoreboard
  import ecap5_dproc_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      issue_i,
  input  reg_addr_t issue_addr_i,
  input  logic      clr_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t rs1_addr_i,
  input  reg_addr_t rs2_addr_i,
  output logic      rs1_pending_o,
  output logic      rs2_pending_o
);

  logic [NB_REGS-1:0] pending_q, pending_d;
  logic               rs1_pending_q, rs2_pending_q;

  // Clear first so a same-cycle set of the same register wins: the newer
  // instruction is still outstanding.
  always_comb begin
    pending_d = pending_q;
    if (clr_i && clr_addr_i != '0)     pending_d[clr_addr_i]   = 1'b0;
    if (issue_i && issue_addr_i != '0) pending_d[issue_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q     <= '0;
      rs1_pending_q <= 1'b0;
      rs2_pending_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      rs1_pending_q <= pending_d[rs1_addr_i];
      rs2_pending_q <= pending_d[rs2_addr_i];
    end
  end

  assign rs1_pending_o = rs1_pending_q;
  assign rs2_pending_o = rs2_pending_q;

endmodule

// File: rtl/register_file.sv
// Integer register file x1..x31 with two registered read ports, write bypass
// and a pending-write scoreboard for decode hazard detection.
module register_file
  import ecap5_dproc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VALUE = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [XLEN-1:0]           rs1_data_o,
  output logic [XLEN-1:0]           rs2_data_o,
  output logic                      rs1_pending_o,
  output logic                      rs2_pending_o,
  input  logic                      issue_i,
  input  logic [REG_ADDR_WIDTH-1:0] issue_addr_i,
  input  logic                      reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_i,
  input  logic [XLEN-1:0]           reg_data_i
);

  logic [XLEN-1:0] regs_q [1:NB_REGS-1];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            wr_en;

  assign wr_en = reg_write_i && (reg_addr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NB_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else if (wr_en) begin
      regs_q[reg_addr_i] <= reg_data_i;
    end
  end

  // x0 reads as zero; a same-cycle write is forwarded so readers never see stale data.
  always_comb begin
    rs1_data_d = '0;
    rs2_data_d = '0;
    if (rs1_addr_i != '0)
      rs1_data_d = (wr_en && reg_addr_i == rs1_addr_i) ? reg_data_i : regs_q[rs1_addr_i];
    if (rs2_addr_i != '0)
      rs2_data_d = (wr_en && reg_addr_i == rs2_addr_i) ? reg_data_i : regs_q[rs2_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign rs1_data_o = rs1_data_q;
  assign rs2_data_o = rs2_data_q;

  reg_scoreboard u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_i       (issue_i),
    .issue_addr_i  (issue_addr_i),
    .clr_i         (reg_write_i),
    .clr_addr_i    (reg_addr_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_pending_o (rs1_pending_o),
    .rs2_pending_o (rs2_pending_o)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  localparam logic [31:0] RV = 32'hC0DE0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_addr_i, reg_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o, reg_data_i;
  logic        rs1_pending_o, rs2_pending_o, issue_i, reg_write_i;

  int n_tests = 0;
  int n_fail  = 0;

  register_file #(.RESET_VALUE(RV)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .rs1_pending_o (rs1_pending_o),
    .rs2_pending_o (rs2_pending_o),
    .issue_i       (issue_i),
    .issue_addr_i  (issue_addr_i),
    .reg_write_i   (reg_write_i),
    .reg_addr_i    (reg_addr_i),
    .reg_data_i    (reg_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are applied mid-cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rs1_addr_i = '0; rs2_addr_i = '0;
    issue_i = 1'b0; issue_addr_i = '0;
    reg_write_i = 1'b0; reg_addr_i = '0; reg_data_i = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write_i = 1'b1; reg_addr_i = a; reg_data_i = d;
  endtask

  function automatic logic [31:0] pat(input int a);
    return (a == 0) ? 32'h0 : (32'hA5A50000 | 32'(a));
  endfunction

  initial begin
    idle();
    rst_ni = 1'b0;
    #22;
    chk("rst_rs1_data", rs1_data_o, 32'h0);
    chk("rst_rs2_data", rs2_data_o, 32'h0);
    chk("rst_pend", {30'h0, rs1_pending_o, rs2_pending_o}, 32'h0);
    rst_ni = 1'b1;
    #3;

    // Reset value visible on x1
    rs1_addr_i = 5'd1; cyc();
    chk("rst_x1", rs1_data_o, RV);

    // Write x5 then read on both ports
    idle(); wr(5'd5, 32'hDEADBEEF); cyc();
    idle(); rs1_addr_i = 5'd5; rs2_addr_i = 5'd5; cyc();
    chk("wr_x5_rs1", rs1_data_o, 32'hDEADBEEF);
    chk("wr_x5_rs2", rs2_data_o, 32'hDEADBEEF);

    // x0 write/issue ignored
    idle(); wr(5'd0, 32'hFFFFFFFF); issue_i = 1'b1; issue_addr_i = 5'd0; cyc();
    chk("x0_data", rs1_data_o, 32'h0);
    chk("x0_pend", {31'h0, rs1_pending_o}, 32'h0);

    // Bypass: clear x7 to 0, then write while reading
    idle(); wr(5'd7, 32'h0); cyc();
    idle(); rs2_addr_i = 5'd7; cyc();
    chk("x7_old", rs2_data_o, 32'h0);
    idle(); wr(5'd7, 32'h12345678); rs2_addr_i = 5'd7; cyc();
    chk("bypass_x7", rs2_data_o, 32'h12345678);

    // Scoreboard: issue x3, poll, retire
    idle(); issue_i = 1'b1; issue_addr_i = 5'd3; rs1_addr_i = 5'd3; cyc();
    chk("sb_set", {31'h0, rs1_pending_o}, 32'h1);
    idle(); rs1_addr_i = 5'd3; cyc();
    chk("sb_hold1", {31'h0, rs1_pending_o}, 32'h1);
    cyc();
    chk("sb_hold2", {31'h0, rs1_pending_o}, 32'h1);
    wr(5'd3, 32'h33330003); cyc();
    chk("sb_clr", {31'h0, rs1_pending_o}, 32'h0);
    chk("sb_clr_data", rs1_data_o, 32'h33330003);

    // Set and clear same register in one cycle: set wins
    idle(); issue_i = 1'b1; issue_addr_i = 5'd3; rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
    wr(5'd3, 32'h0); cyc();
    chk("sb_setwins", {31'h0, rs1_pending_o}, 32'h1);
    chk("sb_other", {31'h0, rs2_pending_o}, 32'h0);
    idle(); rs2_addr_i = 5'd3; wr(5'd3, 32'h1); cyc();
    chk("sb_retire", {31'h0, rs2_pending_o}, 32'h0);

    // Mid-run reset with a write and issue in flight
    idle(); issue_i = 1'b1; issue_addr_i = 5'd9; rs1_addr_i = 5'd9; wr(5'd8, 32'h88888888); cyc();
    chk("pre_rst_pend", {31'h0, rs1_pending_o}, 32'h1);
    wr(5'd10, 32'h10101010); issue_addr_i = 5'd10; #2;
    rst_ni = 1'b0; #1;
    chk("async_rst_pend", {31'h0, rs1_pending_o}, 32'h0);
    cyc(); cyc();
    idle(); #2; rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(i); cyc();
      chk($sformatf("rst_rd_x%0d", i), rs1_data_o, (i == 0) ? 32'h0 : RV);
      chk($sformatf("rst_pend_x%0d", i), {30'h0, rs1_pending_o, rs2_pending_o}, 32'h0);
    end

    // Back-to-back writes x1..x31
    idle();
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), pat(i)); cyc();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(31 - i); cyc();
      chk($sformatf("b2b_rs1_x%0d", i), rs1_data_o, pat(i));
      chk($sformatf("b2b_rs2_x%0d", 31 - i), rs2_data_o, pat(31 - i));
      chk($sformatf("b2b_pend_%0d", i), {30'h0, rs1_pending_o, rs2_pending_o}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
